// File: rtl/filt_ppi_seq_if.sv
// Upstream/downstream handshake bundle for the polyphase sequencer.
// slave = sequencer side, master = source/sink side.
interface filt_ppi_seq_if #(
    parameter int gp_dw = 8,
    parameter int gp_pw = 2
);
    logic             i_valid;
    logic             o_ready;
    logic [gp_dw-1:0] i_data;
    logic [gp_dw-1:0] o_data;
    logic [gp_pw-1:0] o_phase;
    logic             o_valid;
    logic             i_ready;
    logic             o_sclk;
    logic             o_last;

    modport slave (
        input  i_valid, i_data, i_ready,
        output o_ready, o_data, o_phase, o_valid, o_sclk, o_last
    );

    modport master (
        output i_valid, i_data, i_ready,
        input  o_ready, o_data, o_phase, o_valid, o_sclk, o_last
    );
endinterface

// File: rtl/filt_ppi_seq.sv
// Polyphase interpolator commutator: repeats each sample over L phases.
// Optional FILT_PPI_SEQ_UNDERRUN_EN adds a saturating RUN->IDLE counter.
module filt_ppi_seq #(
    parameter int gp_idata_width          = 8,
    parameter int gp_interpolation_factor = 4,
    parameter int gp_comm_ccw             = 1,
    parameter int gp_comm_phase           = 0,
    localparam int lp_pw =
        (gp_interpolation_factor > 2) ? $clog2(gp_interpolation_factor) : 1
) (
    input  logic          i_clk,
    input  logic          i_rst_an,
    input  logic          i_ena,
    filt_ppi_seq_if.slave bus
`ifdef FILT_PPI_SEQ_UNDERRUN_EN
    ,
    output logic [7:0]    o_underrun_cnt
`endif
);
    localparam int lp_l = gp_interpolation_factor;
    localparam int lp_dw = gp_idata_width;
    localparam logic [lp_pw-1:0] lp_s   = lp_pw'(gp_comm_phase);
    localparam logic [lp_pw-1:0] lp_max = lp_pw'(lp_l - 1);
    // Phase whose beat completes a sample: the one just before S in step order
    localparam logic [lp_pw-1:0] lp_last = (gp_comm_ccw != 0)
        ? lp_pw'((gp_comm_phase + lp_l - 1) % lp_l)
        : lp_pw'((gp_comm_phase + 1) % lp_l);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t           r_state, w_state_n;
    logic [lp_dw-1:0] r_cur, w_cur_n;
    logic [lp_dw-1:0] r_hold, w_hold_n;
    logic             r_hf, w_hf_n;
    logic [lp_pw-1:0] r_ph, w_ph_n, w_ph_step;
    logic             r_sclk, w_sclk_n;
    logic             w_run, w_up, w_dn, w_last;

    assign w_run  = (r_state == ST_RUN);
    assign w_last = w_run && (r_ph == lp_last);
    assign w_up   = bus.i_valid && bus.o_ready && i_ena;
    assign w_dn   = w_run && bus.i_ready && i_ena;

    assign bus.o_valid = w_run;
    assign bus.o_ready = i_rst_an && (!w_run || !r_hf);
    assign bus.o_last  = w_last;
    assign bus.o_data  = r_cur;
    assign bus.o_phase = r_ph;
    assign bus.o_sclk  = r_sclk;

    always_comb begin
        w_ph_step = '0;
        if (gp_comm_ccw != 0)
            w_ph_step = (r_ph == lp_max) ? '0 : r_ph + 1'b1;
        else
            w_ph_step = (r_ph == '0) ? lp_max : r_ph - 1'b1;
    end

    always_comb begin
        w_state_n = r_state;
        w_cur_n   = r_cur;
        w_hold_n  = r_hold;
        w_hf_n    = r_hf;
        w_ph_n    = r_ph;
        w_sclk_n  = r_sclk;
        if (i_ena)
            w_sclk_n = w_up;
        unique case (r_state)
            ST_IDLE: begin
                if (w_up) begin
                    w_cur_n   = bus.i_data;
                    w_ph_n    = lp_s;
                    w_state_n = ST_RUN;
                end
            end
            ST_RUN: begin
                // Stepping from the last phase always lands back on S
                if (w_dn)
                    w_ph_n = w_ph_step;
                if (w_dn && w_last) begin
                    if (r_hf) begin
                        w_cur_n = r_hold;
                        w_hf_n  = 1'b0;
                    end else if (w_up) begin
                        w_cur_n = bus.i_data;
                    end else begin
                        w_state_n = ST_IDLE;
                    end
                end else if (w_up) begin
                    w_hold_n = bus.i_data;
                    w_hf_n   = 1'b1;
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_an) begin
            r_state <= ST_IDLE;
            r_cur   <= '0;
            r_hold  <= '0;
            r_hf    <= 1'b0;
            r_ph    <= lp_s;
            r_sclk  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cur   <= w_cur_n;
            r_hold  <= w_hold_n;
            r_hf    <= w_hf_n;
            r_ph    <= w_ph_n;
            r_sclk  <= w_sclk_n;
        end
    end

`ifdef FILT_PPI_SEQ_UNDERRUN_EN
    logic [7:0] r_underrun;
    logic       w_underrun;

    assign w_underrun     = w_run && (w_state_n == ST_IDLE);
    assign o_underrun_cnt = r_underrun;

    always_ff @(posedge i_clk) begin
        if (!i_rst_an)
            r_underrun <= '0;
        else if (w_underrun && (r_underrun != 8'hFF))
            r_underrun <= r_underrun + 8'd1;
    end
`endif
endmodule

// File: doc/filt_ppi_seq.md
FILT_PPI_SEQ -- requirements
Module: filt_ppi_seq

Interface
REQ-001 SHALL have parameter gp_idata_width, default 8: input sample width, signed.
REQ-002 SHALL have parameter gp_interpolation_factor, default 4: number of polyphase branches L, where L >= 2.
REQ-003 SHALL have parameter gp_comm_ccw, default 1: 1 steps the phase index up mod L; 0 steps it down mod L.
REQ-004 SHALL have parameter gp_comm_phase, default 0: start phase S, where 0 <= S < L.
REQ-005 SHALL have localparam lp_pw = max(1, clog2(L)): phase index width.
REQ-006 i_clk  in  1  single rising-edge clock; one clock, no other clock domain.
REQ-007 i_rst_an  in  1  reset, synchronous and active-low.
REQ-008 i_ena  in  1  synchronous active-high enable.
REQ-009 i_valid  in  1  upstream sample valid.
REQ-010 o_ready  out  1  upstream sample ready.
REQ-011 i_data  in  gp_idata_width  upstream sample, signed.
REQ-012 o_data  out  gp_idata_width  sample currently being sequenced.
REQ-013 o_phase  out  lp_pw  polyphase branch / coefficient bank select.
REQ-014 o_valid  out  1  branch beat valid.
REQ-015 i_ready  in  1  downstream accepts beat.
REQ-016 o_sclk  out  1  one-cycle strobe on each upstream sample accept.
REQ-017 o_last  out  1  high with the final phase beat of a sample.

Function
REQ-018 Upstream transfer SHALL occur when i_valid && o_ready && i_ena; downstream beat SHALL occur when o_valid && i_ready && i_ena.
REQ-019 The block SHALL hold a current register (cur) and a one-deep hold register (hold), plus a phase counter ph.
REQ-020 The FSM SHALL have two states. IDLE: o_valid=0, o_ready=1. RUN: o_valid=1, o_ready=!hold_full.
REQ-021 IDLE->RUN on upstream transfer: cur<=i_data, ph<=S; o_valid SHALL rise the next cycle (latency 1).
REQ-022 In RUN, each downstream beat SHALL advance ph by +1 mod L when ccw and by -1 mod L when cw.
REQ-023 o_last SHALL be high when ph == S-1 mod L (ccw) or ph == S+1 mod L (cw), and only while o_valid is high.
REQ-024 On a last beat with hold_full, cur<=hold, hold_full<=0, ph<=S, and the FSM SHALL stay in RUN with no bubble.
REQ-025 On a last beat without hold_full and with a simultaneous upstream transfer, cur<=i_data and the FSM SHALL stay in RUN with no bubble.
REQ-026 On a last beat with no pending sample, the FSM SHALL go to IDLE.
REQ-027 An upstream transfer in RUN that is not consumed per REQ-025 SHALL write hold; o_ready SHALL drop the following cycle.
REQ-028 o_sclk SHALL equal the registered upstream-transfer event, high one cycle after accept.
REQ-029 o_data SHALL equal cur; o_phase SHALL equal ph.
REQ-030 If i_ready is low, ph, o_data and o_valid SHALL hold; stall duration is unbounded.
REQ-031 If i_ena is low, all state SHALL be frozen, no transfers SHALL occur, and outputs SHALL hold their values.
REQ-032 Phase wrap SHALL be modulo L, including non-power-of-two L (e.g. L=3: ccw sequence 0,1,2,0).

Reset
REQ-033 With i_rst_an low at a rising edge: FSM=IDLE, ph=S, cur=0, hold=0, hold_full=0; o_valid=0, o_ready=0, o_sclk=0, o_last=0, o_data=0, o_phase=S.
REQ-034 o_ready SHALL become 1 on the first cycle after reset release.
REQ-035 A reset asserted mid-sequence SHALL discard cur and hold with no partial-beat completion.
REQ-036 Reset SHALL take priority over i_ena.

Configuration
REQ-037 When macro FILT_PPI_SEQ_UNDERRUN_EN is defined, output o_underrun_cnt [7:0] SHALL be added.
REQ-038 With the macro defined, o_underrun_cnt SHALL increment on each RUN->IDLE transition, SHALL saturate at 255, and SHALL reset to 0.
REQ-039 With the macro undefined, the port and its logic SHALL be absent; behaviour is otherwise identical.

Verification
REQ-040 L=4, S=0, ccw; one sample 0x35, i_ready=1 -> o_phase 0,1,2,3 on cycles +1..+4, o_data=0x35, o_last on phase 3, then IDLE.
REQ-041 L=3, S=2, cw; continuous i_valid with samples A,B -> phases 2,1,0,2,1,0, no bubble, o_sclk twice.
REQ-042 L=4; i_ready low for 5 cycles at phase 1 -> o_phase=1 held, hold fills, o_ready=0, no sample lost.
REQ-043 i_ena low for 3 cycles mid-sequence -> outputs frozen; sequence resumes at the same phase.
REQ-044 Reset asserted at phase 2 -> next cycle o_valid=0, o_phase=S, o_data=0.
REQ-045 FILT_PPI_SEQ_UNDERRUN_EN defined; 300 isolated samples -> o_underrun_cnt=255.
